// File: rtl/osc_step_sequencer_if.sv
// Front-panel / oscillator-side bundle for osc_step_sequencer.
// master = pattern/run controller, slave = the sequencer itself.
interface osc_step_sequencer_if #(
  parameter int STEPS   = 8,
  parameter int TOP_W   = 17,
  parameter int TEMPO_W = 24
);
  localparam int SW = $clog2(STEPS);

  logic               run;
  logic [TEMPO_W-1:0] tempo_div;
  logic [TEMPO_W-1:0] gate_len;
  logic [SW-1:0]      last_step;
  logic               wr_en;
  logic [SW-1:0]      wr_addr;
  logic [TOP_W:0]     wr_data;

  logic [TOP_W-1:0]   counter_top;
  logic               osc_rst;
  logic               gate;
  logic               step_pulse;
  logic [SW-1:0]      cur_step;

  modport master (
    output run, tempo_div, gate_len, last_step, wr_en, wr_addr, wr_data,
    input  counter_top, osc_rst, gate, step_pulse, cur_step
  );

  modport slave (
    input  run, tempo_div, gate_len, last_step, wr_en, wr_addr, wr_data,
    output counter_top, osc_rst, gate, step_pulse, cur_step
  );
endinterface

// File: rtl/osc_step_sequencer.sv
// Step sequencer: plays stored counter_top values at a programmable tempo for one oscillator.
// Optional OSC_SEQ_GLIDE_EN: counter_top slews toward each new step instead of jumping.
module osc_step_sequencer #(
  parameter int STEPS   = 8,
  parameter int TOP_W   = 17,
  parameter int TEMPO_W = 24
`ifdef OSC_SEQ_GLIDE_EN
  ,
  parameter int GLIDE_SHIFT = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  osc_step_sequencer_if.slave  seq_if
);

  localparam int SW = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD0,
    PLAY
  } state_e;

  typedef struct packed {
    logic             rest;
    logic [TOP_W-1:0] top;
  } entry_t;

  entry_t             mem_q [STEPS];
  state_e             state_q;
  logic [TEMPO_W-1:0] tick_q;
  logic [TOP_W-1:0]   counter_top_q;
  logic               osc_rst_q;
  logic               gate_q;
  logic               step_pulse_q;
  logic [SW-1:0]      cur_step_q;

  logic               advance;
  logic               load_now;
  logic [SW-1:0]      next_idx;
  logic [SW-1:0]      load_idx;
  entry_t             load_entry;
  logic [TEMPO_W-1:0] tick_inc;

  // NOTE: the pattern is a small flop array, so it can take a reset; every entry powers up as a silent rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_q[i] <= {1'b1, {TOP_W{1'b0}}};
      end
    end else if (seq_if.wr_en) begin
      mem_q[seq_if.wr_addr] <= entry_t'(seq_if.wr_data);
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    advance  = (seq_if.tempo_div != '0) && (tick_q >= (seq_if.tempo_div - TEMPO_W'(1)));
    next_idx = (cur_step_q >= seq_if.last_step) ? '0 : cur_step_q + SW'(1);
    load_idx = (state_q == LOAD0) ? '0 : next_idx;
    load_now = (state_q == LOAD0) || ((state_q == PLAY) && seq_if.run && advance);
    tick_inc = tick_q + TEMPO_W'(1);
    // A write landing on the entry being loaded this edge wins over the stored value.
    if (seq_if.wr_en && (seq_if.wr_addr == load_idx)) begin
      load_entry = entry_t'(seq_if.wr_data);
    end else begin
      load_entry = mem_q[load_idx];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      osc_rst_q    <= 1'b1;
      gate_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      cur_step_q   <= '0;
    end else begin
      step_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seq_if.run) state_q <= LOAD0;
        end
        LOAD0: begin
          state_q      <= PLAY;
          tick_q       <= '0;
          step_pulse_q <= 1'b1;
          cur_step_q   <= '0;
          osc_rst_q    <= load_entry.rest;
          gate_q       <= ~load_entry.rest & (seq_if.gate_len != '0);
        end
        PLAY: begin
          if (!seq_if.run) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            gate_q    <= 1'b0;
            osc_rst_q <= 1'b1;
          end else if (advance) begin
            tick_q       <= '0;
            step_pulse_q <= 1'b1;
            cur_step_q   <= next_idx;
            osc_rst_q    <= load_entry.rest;
            gate_q       <= ~load_entry.rest & (seq_if.gate_len != '0);
          end else if (seq_if.tempo_div != '0) begin
            tick_q <= tick_inc;
            gate_q <= ~osc_rst_q & (tick_inc < seq_if.gate_len);
          end else begin
            // Frozen tempo: tick holds, gate still tracks a live gate_len.
            gate_q <= ~osc_rst_q & (tick_q < seq_if.gate_len);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OSC_SEQ_GLIDE_EN
  localparam int GW = GLIDE_SHIFT + 1;
  localparam logic [GW-1:0] GLIDE_MASK = GW'((1 << GLIDE_SHIFT) - 1);

  logic [TOP_W-1:0] target_q;
  logic [GW-1:0]    glide_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_top_q <= '0;
      target_q      <= '0;
      glide_cnt_q   <= '0;
    end else if (load_now) begin
      glide_cnt_q <= '0;
      if (load_entry.rest) begin
        target_q <= counter_top_q;
      end else if ((state_q == LOAD0) || osc_rst_q) begin
        // Coming out of silence there is nothing audible to slide from.
        counter_top_q <= load_entry.top;
        target_q      <= load_entry.top;
      end else begin
        target_q <= load_entry.top;
      end
    end else if ((state_q == PLAY) && seq_if.run) begin
      if (glide_cnt_q == GLIDE_MASK) begin
        glide_cnt_q <= '0;
        if (counter_top_q < target_q) begin
          counter_top_q <= counter_top_q + TOP_W'(1);
        end else if (counter_top_q > target_q) begin
          counter_top_q <= counter_top_q - TOP_W'(1);
        end
      end else begin
        glide_cnt_q <= glide_cnt_q + GW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_top_q <= '0;
    end else if (load_now && !load_entry.rest) begin
      counter_top_q <= load_entry.top;
    end
  end
`endif

  assign seq_if.counter_top = counter_top_q;
  assign seq_if.osc_rst     = osc_rst_q;
  assign seq_if.gate        = gate_q;
  assign seq_if.step_pulse  = step_pulse_q;
  assign seq_if.cur_step    = cur_step_q;

endmodule

// File: tb/tb_osc_step_sequencer.sv
// Directed bench for osc_step_sequencer; expected values are hand-derived from the step timing.
module tb_osc_step_sequencer;
  localparam int STEPS   = 8;
  localparam int TOP_W   = 17;
  localparam int TEMPO_W = 24;
  localparam int SW      = $clog2(STEPS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  osc_step_sequencer_if #(.STEPS(STEPS), .TOP_W(TOP_W), .TEMPO_W(TEMPO_W)) seq_if ();

  osc_step_sequencer #(
    .STEPS(STEPS),
    .TOP_W(TOP_W),
    .TEMPO_W(TEMPO_W)
`ifdef OSC_SEQ_GLIDE_EN
    ,
    .GLIDE_SHIFT(0)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seq_if(seq_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input int addr, input logic [TOP_W:0] data);
    seq_if.wr_en   = 1'b1;
    seq_if.wr_addr = SW'(addr);
    seq_if.wr_data = data;
    @(negedge clk);
    seq_if.wr_en = 1'b0;
  endtask

  // Waits for step_pulse; reports how many negedges it took (or the budget if it never came).
  task automatic wait_pulse(input string tag, input int max_cyc, input int exp_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((seq_if.step_pulse !== 1'b1) && (n < max_cyc));
    check(tag, n, exp_cyc);
  endtask

  // Called on the negedge right after a step load; leaves on the negedge after the next load.
  task automatic play_step(input string tag, input int idx, input logic [TOP_W-1:0] top,
                           input logic rest, input int gate_hi, input int period);
    int hi;
    int extra;
    hi    = 0;
    extra = 0;
    check({tag, ".pulse"}, seq_if.step_pulse, 1);
    check({tag, ".step"}, seq_if.cur_step, idx);
    check({tag, ".top"}, seq_if.counter_top, top);
    check({tag, ".osc_rst"}, seq_if.osc_rst, rest);
    for (int i = 0; i < period; i++) begin
      if (seq_if.gate === 1'b1) hi++;
      if ((i > 0) && (seq_if.step_pulse !== 1'b0)) extra++;
      @(negedge clk);
    end
    check({tag, ".gate_hi"}, hi, gate_hi);
    check({tag, ".early_pulse"}, extra, 0);
  endtask

  initial begin
    int pulses;
    seq_if.run       = 1'b0;
    seq_if.tempo_div = '0;
    seq_if.gate_len  = '0;
    seq_if.last_step = '0;
    seq_if.wr_en     = 1'b0;
    seq_if.wr_addr   = '0;
    seq_if.wr_data   = '0;

    repeat (3) @(negedge clk);
    check("rst.top", seq_if.counter_top, 0);
    check("rst.osc_rst", seq_if.osc_rst, 1);
    check("rst.gate", seq_if.gate, 0);
    check("rst.pulse", seq_if.step_pulse, 0);
    check("rst.step", seq_if.cur_step, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef OSC_SEQ_GLIDE_EN
    write_entry(0, 18'h00200);
    write_entry(1, 18'h00204);
    seq_if.last_step = SW'(1);
    seq_if.tempo_div = 24'd10;
    seq_if.gate_len  = 24'd5;
    seq_if.run       = 1'b1;
    wait_pulse("glide.start", 6, 2);
    check("glide.first_jump", seq_if.counter_top, 32'h200);
    repeat (10) @(negedge clk);
    check("glide.load_pulse", seq_if.step_pulse, 1);
    check("glide.load_top", seq_if.counter_top, 32'h200);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("glide.slew", seq_if.counter_top, 32'h200 + k);
    end
    @(negedge clk);
    check("glide.settled", seq_if.counter_top, 32'h204);
`else
    // Four-step pattern, 10-clock steps, 5-clock gate.
    write_entry(0, 18'h00200);
    write_entry(1, 18'h00400);
    write_entry(2, 18'h00800);
    write_entry(3, 18'h01000);
    seq_if.last_step = SW'(3);
    seq_if.tempo_div = 24'd10;
    seq_if.gate_len  = 24'd5;
    seq_if.run       = 1'b1;
    wait_pulse("start.latency", 6, 2);
    play_step("s0", 0, 17'h00200, 1'b0, 5, 10);
    play_step("s1", 1, 17'h00400, 1'b0, 5, 10);
    play_step("s2", 2, 17'h00800, 1'b0, 5, 10);
    play_step("s3", 3, 17'h01000, 1'b0, 5, 10);
    play_step("s0_wrap", 0, 17'h00200, 1'b0, 5, 10);

    // Entry 2 becomes a rest while step 1 sounds.
    seq_if.wr_en   = 1'b1;
    seq_if.wr_addr = SW'(2);
    seq_if.wr_data = 18'h20800;
    play_step("r1", 1, 17'h00400, 1'b0, 5, 10);
    seq_if.wr_en = 1'b0;
    play_step("r2_rest", 2, 17'h00400, 1'b1, 0, 10);
    play_step("r3", 3, 17'h01000, 1'b0, 5, 10);
    play_step("r0", 0, 17'h00200, 1'b0, 5, 10);

    // Legato, then a mid-step tempo cut.
    seq_if.gate_len = 24'd10;
    seq_if.wr_en    = 1'b1;
    seq_if.wr_addr  = SW'(2);
    seq_if.wr_data  = 18'h00800;
    play_step("l1", 1, 17'h00400, 1'b0, 10, 10);
    seq_if.wr_en = 1'b0;
    play_step("l2", 2, 17'h00800, 1'b0, 10, 10);
    check("l3.top", seq_if.counter_top, 32'h1000);
    check("l3.gate", seq_if.gate, 1);
    repeat (6) @(negedge clk);
    check("l3.no_pulse_tick6", seq_if.step_pulse, 0);
    check("l3.gate_tick6", seq_if.gate, 1);
    seq_if.tempo_div = 24'd3;
    @(negedge clk);
    check("tempo_cut.pulse", seq_if.step_pulse, 1);
    check("tempo_cut.step", seq_if.cur_step, 0);
    check("tempo_cut.top", seq_if.counter_top, 32'h200);
    seq_if.tempo_div = 24'd10;
    seq_if.gate_len  = 24'd5;

    // Write to entry 1 on the very edge it loads.
    repeat (9) @(negedge clk);
    seq_if.wr_en   = 1'b1;
    seq_if.wr_addr = SW'(1);
    seq_if.wr_data = 18'h00123;
    @(negedge clk);
    seq_if.wr_en = 1'b0;
    check("bypass.pulse", seq_if.step_pulse, 1);
    check("bypass.step", seq_if.cur_step, 1);
    check("bypass.top", seq_if.counter_top, 32'h123);

    seq_if.run = 1'b0;
    @(negedge clk);
    check("stop.gate", seq_if.gate, 0);
    check("stop.osc_rst", seq_if.osc_rst, 1);
    check("stop.step_hold", seq_if.cur_step, 1);
    check("stop.top_hold", seq_if.counter_top, 32'h123);
    check("stop.pulse", seq_if.step_pulse, 0);

    seq_if.run = 1'b1;
    wait_pulse("restart.latency", 6, 2);
    check("restart.step", seq_if.cur_step, 0);
    check("restart.top", seq_if.counter_top, 32'h200);

    // tempo_div = 0 freezes the step.
    seq_if.tempo_div = '0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (seq_if.step_pulse === 1'b1) pulses++;
    end
    check("freeze.pulses", pulses, 0);
    check("freeze.step", seq_if.cur_step, 0);
    check("freeze.gate", seq_if.gate, 1);
    seq_if.tempo_div = 24'd10;
    wait_pulse("unfreeze.latency", 15, 10);
    check("unfreeze.step", seq_if.cur_step, 1);
    check("unfreeze.top", seq_if.counter_top, 32'h123);

    // Asynchronous reset in the middle of a step.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst.gate", seq_if.gate, 0);
    check("async_rst.osc_rst", seq_if.osc_rst, 1);
    check("async_rst.top", seq_if.counter_top, 0);
    check("async_rst.step", seq_if.cur_step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse("post_rst.latency", 6, 2);
    check("post_rst.osc_rst", seq_if.osc_rst, 1);
    check("post_rst.gate", seq_if.gate, 0);
    check("post_rst.top", seq_if.counter_top, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
